// File: rtl/qam16_symbol_mux.sv
// qam16_symbol_mux: collects a serial bit stream into 4-bit symbols through a
// one-deep pending buffer and, at every 16-sample carrier-period boundary,
// selects one of the 16 waveform lanes (Q00..Q33) as the registered output.
// Optional build macro: QAM16_GRAY_MAP_EN (Gray-coded I/Q axes, default off).

module qam16_symbol_mux #(
    parameter int unsigned     DW         = 8,
    parameter logic [DW-1:0]   IDLE_LEVEL = DW'(100)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [16*DW-1:0]   wave_bus,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic               bit_ready,
    output logic [DW-1:0]      mod_out,
    output logic               sym_start,
    output logic               underrun
);

    logic [3:0]    phase;
    logic [2:0]    bcnt;
    logic [3:0]    shreg;
    logic [3:0]    pend;
    logic          pend_v;
    logic [3:0]    act_sym;
    logic          act_v;

    logic          accept;
    logic          load;
    logic          transfer;
    logic [DW-1:0] lane_sel;

    // Symbol-to-lane mapping; each 2-bit axis is Gray-decoded when enabled.
    function automatic logic [3:0] map_sym(input logic [3:0] s);
`ifdef QAM16_GRAY_MAP_EN
        return {s[3], s[3] ^ s[2], s[1], s[1] ^ s[0]};
`else
        return s;
`endif
    endfunction

    // Handshake, period-boundary and transfer decisions, plus lane selection.
    always_comb begin
        bit_ready = (bcnt != 3'd4);
        accept    = bit_valid && bit_ready;
        load      = (phase == 4'hF);
        // A load empties the buffer in the same cycle, so a full shift
        // register may refill it on the boundary without a gap.
        transfer  = (bcnt == 3'd4) && (!pend_v || load);
        lane_sel  = wave_bus[act_sym*DW +: DW];
    end

    // Free-running phase counter, in step with the generators' sample index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= '0;
        end else begin
            phase <= phase + 4'd1;
        end
    end

    // Bit capture into the shift register and transfer into the pending slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcnt   <= '0;
            shreg  <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
        end else begin
            if (transfer) begin
                pend   <= shreg;
                pend_v <= 1'b1;
                bcnt   <= '0;
            end else begin
                if (load) begin
                    pend_v <= 1'b0;
                end
                if (accept) begin
                    shreg <= {shreg[2:0], bit_in};
                    bcnt  <= bcnt + 3'd1;
                end
            end
        end
    end

    // Symbol load at the period boundary; an empty buffer idles the next period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_sym <= '0;
            act_v   <= 1'b0;
        end else if (load) begin
            if (pend_v) begin
                act_sym <= map_sym(pend);
                act_v   <= 1'b1;
            end else begin
                act_v   <= 1'b0;
            end
        end
    end

    // Registered output sample, period-start marker and underrun pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mod_out   <= IDLE_LEVEL;
            sym_start <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            mod_out   <= act_v ? lane_sel : IDLE_LEVEL;
            sym_start <= (phase == 4'd0);
            underrun  <= load && !pend_v;
        end
    end

endmodule

// File: tb/tb_qam16_symbol_mux.sv
// tb_qam16_symbol_mux: directed and randomized stimulus checked against a
// queue-based behavioural model of the symbol mux.
// Honours QAM16_GRAY_MAP_EN the same way the design does.

module tb_qam16_symbol_mux;

    localparam int          DW   = 8;
    localparam logic [7:0]  IDLE = 8'd100;

`ifdef QAM16_GRAY_MAP_EN
    localparam int DIR_1011 = 140;
    localparam int DIR_0110 = 70;
    localparam int DIR_1100 = 80;
`else
    localparam int DIR_1011 = 110;
    localparam int DIR_0110 = 60;
    localparam int DIR_1100 = 120;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [16*DW-1:0]  wave_bus = '0;
    logic              bit_in = 1'b0;
    logic              bit_valid = 1'b0;
    logic              bit_ready;
    logic [DW-1:0]     mod_out;
    logic              sym_start;
    logic              underrun;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] lanes [16];
    bit  lane_rand = 1'b0;
    int  part[$];
    int  pend[$];
    int  active = -1;
    int  cyc = 0;
    int  exp_mod, exp_ss, exp_ur;
    bit  acc;
    int  ur_seen = 0;

    qam16_symbol_mux #(
        .DW         (DW),
        .IDLE_LEVEL (IDLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wave_bus  (wave_bus),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .mod_out   (mod_out),
        .sym_start (sym_start),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int lane_of(input int s);
`ifdef QAM16_GRAY_MAP_EN
        int gm[4] = '{0, 1, 3, 2};
        return gm[s / 4] * 4 + gm[s % 4];
`else
        return s;
`endif
    endfunction

    // One clock: drive inputs, predict, advance the model, then check outputs.
    task automatic cycle(input bit v, input bit b, input bit r);
        bit_valid = v;
        bit_in    = b;
        rst_n     = r;
        for (int k = 0; k < 16; k++) begin
            lanes[k] = lane_rand ? 8'($urandom) : 8'(10 * k);
            wave_bus[k*DW +: DW] = lanes[k];
        end
        #1;
        acc = 1'b0;
        if (!r) begin
            part.delete();
            pend.delete();
            active  = -1;
            cyc     = 0;
            exp_mod = IDLE;
            exp_ss  = 0;
            exp_ur  = 0;
        end else begin
            check("bit_ready", int'(bit_ready), int'(part.size() != 4));
            exp_mod = (active < 0) ? int'(IDLE) : int'(lanes[lane_of(active)]);
            exp_ss  = int'(cyc % 16 == 0);
            exp_ur  = int'((cyc % 16 == 15) && (pend.size() == 0));
            if (cyc % 16 == 15) begin
                if (pend.size() > 0) active = pend.pop_front();
                else                 active = -1;
            end
            if (part.size() == 4) begin
                if (pend.size() == 0) begin
                    pend.push_back(part[0]*8 + part[1]*4 + part[2]*2 + part[3]);
                    part.delete();
                end
            end else if (v) begin
                part.push_back(int'(b));
                acc = 1'b1;
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        check("mod_out", int'(mod_out), exp_mod);
        check("sym_start", int'(sym_start), exp_ss);
        check("underrun", int'(underrun), exp_ur);
        if (underrun === 1'b1) ur_seen++;
    endtask

    initial begin
        int q[$];
        bit found;

        // Reset
        cycle(0, 0, 0);
        cycle(0, 0, 0);

        // Single symbol 1011 from phase 0
        cycle(1, 1, 1);
        cycle(1, 0, 1);
        cycle(1, 1, 1);
        cycle(1, 1, 1);
        repeat (6) cycle(0, 0, 1);
        check("pre_symbol_idle", int'(mod_out), int'(IDLE));
        repeat (12) cycle(0, 0, 1);
        check("lane_1011", int'(mod_out), DIR_1011);
        // Starvation: underrun at the next boundary, then an idle period
        repeat (26) cycle(0, 0, 1);
        check("idle_after_underrun", int'(mod_out), int'(IDLE));

        // Continuous valid: symbols 0000..0111
        for (int s = 0; s < 8; s++)
            for (int i = 3; i >= 0; i--) q.push_back((s >> i) & 1);
        for (int n = 0; n < 200; n++) begin
            cycle(q.size() > 0, (q.size() > 0) ? bit'(q[0]) : 1'b0, 1);
            if (acc && q.size() > 0) void'(q.pop_front());
        end
        check("stream_consumed", q.size(), 0);

        // Set up phase 7, active symbol, two bits captured; then reset
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            if (cyc % 16 == 7 && part.size() == 2 && active >= 0) begin
                found = 1'b1;
            end else begin
                if (active < 0 || pend.size() > 0)
                    cycle(pend.size() == 0 && part.size() < 4, bit'($urandom), 1);
                else
                    cycle((cyc % 16 == 5) || (cyc % 16 == 6), bit'($urandom), 1);
            end
        end
        check("reset_setup_reached", int'(found), 1);
        cycle(0, 0, 0);
        check("reset_idle", int'(mod_out), int'(IDLE));

        // Fresh 0110, then 1100 whose transfer coincides with phase 15
        ur_seen = 0;
        cycle(1, 0, 1);
        cycle(1, 1, 1);
        cycle(1, 1, 1);
        cycle(1, 0, 1);
        repeat (7) cycle(0, 0, 1);
        cycle(1, 1, 1);
        cycle(1, 1, 1);
        cycle(1, 0, 1);
        cycle(1, 0, 1);
        repeat (7) cycle(0, 0, 1);
        check("lane_0110_after_reset", int'(mod_out), DIR_0110);
        repeat (16) cycle(0, 0, 1);
        check("lane_1100_refill", int'(mod_out), DIR_1100);
        check("no_underrun_on_refill", ur_seen, 0);

        // Randomized traffic with random lanes and occasional reset
        lane_rand = 1'b1;
        for (int n = 0; n < 1500; n++)
            cycle($urandom_range(99) < 35, bit'($urandom), $urandom_range(399) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
